// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue.
package wb_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam logic [4:0]  REG_ZERO      = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: MEM/EX result handshakes, register-file write port, decode reads.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface wb_queue_if;

    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        ex_valid;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        ex_ready;

    logic        we;
    logic [4:0]  wAddr;
    logic [31:0] wData;

    logic [4:0]  regaAddr;
    logic [4:0]  regbAddr;

`ifdef WB_BYPASS_EN
    logic        fwdaHit;
    logic        fwdbHit;
    logic [31:0] fwdaData;
    logic [31:0] fwdbData;

    modport master (
        output mem_valid, mem_addr, mem_data, ex_valid, ex_addr, ex_data, regaAddr, regbAddr,
        input  mem_ready, ex_ready, we, wAddr, wData, fwdaHit, fwdbHit, fwdaData, fwdbData
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, ex_valid, ex_addr, ex_data, regaAddr, regbAddr,
        output mem_ready, ex_ready, we, wAddr, wData, fwdaHit, fwdbHit, fwdaData, fwdbData
    );
`else
    modport master (
        output mem_valid, mem_addr, mem_data, ex_valid, ex_addr, ex_data, regaAddr, regbAddr,
        input  mem_ready, ex_ready, we, wAddr, wData
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, ex_valid, ex_addr, ex_data, regaAddr, regbAddr,
        output mem_ready, ex_ready, we, wAddr, wData
    );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Pending-write storage: two push ports (push0 older than push1), one pop port, occupancy count.
// With WB_BYPASS_EN the entries are also exported oldest-first for bypass lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push0,
    input  wb_entry_t       push0_entry,
    input  logic            push1,
    input  wb_entry_t       push1_entry,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CntW-1:0] count
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t       ordered [DEPTH]
`endif
);

    wb_entry_t       mem [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] wr_ptr_1;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        // push1 lands behind push0 only when push0 is also writing this cycle
        wr_ptr_1 = push0 ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PtrW'(push0) + PtrW'(push1);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        count_d  = count_q + CntW'(push0) + CntW'(push1) - CntW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr_q] <= push0_entry;
        if (push1) mem[wr_ptr_1] <= push1_entry;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

`ifdef WB_BYPASS_EN
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ordered[i] = mem[rd_ptr_q + PtrW'(i)];
        end
    end
`endif

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges MEM and EX results in program order into one register-file write port.
// Optional pending-write bypass to decode is enabled by defining WB_BYPASS_EN.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input logic      clk,
    input logic      rst,
    wb_queue_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [CntW-1:0] count;
    logic [CntW-1:0] free;
    logic            mem_enq_req;
    logic            ex_enq_req;
    logic            mem_push;
    logic            ex_push;
    logic            pop;
    wb_entry_t       head;
    wb_entry_t       mem_entry;
    wb_entry_t       ex_entry;

    // Space comes from the registered count only; this cycle's pop is not credited.
    assign free        = CntW'(DEPTH) - count;
    assign mem_enq_req = bus.mem_valid && (bus.mem_addr != REG_ZERO);
    assign ex_enq_req  = bus.ex_valid && (bus.ex_addr != REG_ZERO);

    assign bus.mem_ready = (free != '0);
    assign bus.ex_ready  = bus.mem_ready && ((free > CntW'(1)) || !mem_enq_req);

    assign mem_push  = mem_enq_req && bus.mem_ready;
    assign ex_push   = ex_enq_req && bus.ex_ready;
    assign mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
    assign ex_entry  = '{addr: bus.ex_addr, data: bus.ex_data};
    assign pop       = (count != '0);

    assign bus.we    = pop;
    assign bus.wAddr = pop ? head.addr : REG_ZERO;
    assign bus.wData = pop ? head.data : 32'd0;

`ifdef WB_BYPASS_EN
    wb_entry_t ordered [DEPTH];

    // Entries are scanned oldest to youngest so the last match wins.
    always_comb begin
        bus.fwdaHit  = 1'b0;
        bus.fwdaData = 32'd0;
        bus.fwdbHit  = 1'b0;
        bus.fwdbData = 32'd0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CntW'(i) < count) begin
                if ((bus.regaAddr != REG_ZERO) && (ordered[i].addr == bus.regaAddr)) begin
                    bus.fwdaHit  = 1'b1;
                    bus.fwdaData = ordered[i].data;
                end
                if ((bus.regbAddr != REG_ZERO) && (ordered[i].addr == bus.regbAddr)) begin
                    bus.fwdbHit  = 1'b1;
                    bus.fwdbData = ordered[i].data;
                end
            end
        end
    end
`else
    logic unused_read_addr;
    assign unused_read_addr = ^{bus.regaAddr, bus.regbAddr};
`endif

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0       (mem_push),
        .push0_entry (mem_entry),
        .push1       (ex_push),
        .push1_entry (ex_entry),
        .pop         (pop),
        .head        (head),
        .count       (count)
`ifdef WB_BYPASS_EN
        ,
        .ordered     (ordered)
`endif
    );

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, reset/bypass sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    wb_queue_if bus_if ();

    wb_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];

    typedef struct {
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        mr;
        logic        er;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic [4:0] ra, input logic [4:0] rb);
        bus_if.mem_valid = mv;
        bus_if.mem_addr  = ma;
        bus_if.mem_data  = md;
        bus_if.ex_valid  = ev;
        bus_if.ex_addr   = ea;
        bus_if.ex_data   = ed;
        bus_if.regaAddr  = ra;
        bus_if.regbAddr  = rb;
    endtask

    task automatic model_ready(output bit mr, output bit er);
        int free;
        bit mem_enq;
        free    = int'(DEPTH) - mq.size();
        mem_enq = bus_if.mem_valid && (bus_if.mem_addr != 5'd0);
        mr      = (free >= 1);
        er      = mr && ((free >= 2) || !mem_enq);
    endtask

    task automatic model_lookup(input logic [4:0] ra, output bit hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (ra != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].a == ra) begin
                    hit  = 1'b1;
                    data = mq[i].d;
                end
            end
        end
    endtask

    task automatic model_check();
        bit mr, er;
        bit hit;
        logic [31:0] hd;
        model_ready(mr, er);
        check("mem_ready", 32'(bus_if.mem_ready), 32'(mr));
        check("ex_ready", 32'(bus_if.ex_ready), 32'(er));
        check("we", 32'(bus_if.we), 32'(mq.size() != 0));
        check("wAddr", 32'(bus_if.wAddr), (mq.size() != 0) ? 32'(mq[0].a) : 32'd0);
        check("wData", bus_if.wData, (mq.size() != 0) ? mq[0].d : 32'd0);
`ifdef WB_BYPASS_EN
        model_lookup(bus_if.regaAddr, hit, hd);
        check("fwdaHit", 32'(bus_if.fwdaHit), 32'(hit));
        check("fwdaData", bus_if.fwdaData, hd);
        model_lookup(bus_if.regbAddr, hit, hd);
        check("fwdbHit", 32'(bus_if.fwdbHit), 32'(hit));
        check("fwdbData", bus_if.fwdbData, hd);
`else
        hit = 1'b0;
        hd  = 32'd0;
`endif
    endtask

    // Called just after the edge: inputs are still the ones the edge sampled.
    task automatic model_advance(input bit mr, input bit er);
        if (mq.size() != 0) void'(mq.pop_front());
        if (bus_if.mem_valid && mr && (bus_if.mem_addr != 5'd0))
            mq.push_back('{a: bus_if.mem_addr, d: bus_if.mem_data});
        if (bus_if.ex_valid && er && (bus_if.ex_addr != 5'd0))
            mq.push_back('{a: bus_if.ex_addr, d: bus_if.ex_data});
    endtask

    task automatic run_cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                             input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                             input logic [4:0] ra, input logic [4:0] rb);
        bit mr, er;
        drive(mv, ma, md, ev, ea, ed, ra, rb);
        @(negedge clk);
        model_check();
        model_ready(mr, er);
        @(posedge clk);
        model_advance(mr, er);
        #1;
    endtask

    initial begin
        bit mr, er;
        tests = 0;
        fails = 0;

        //           mv ma  md          ev ea  ed          mr er we wa  wd
        vt[0]  = '{1, 5, 32'h1234, 0, 0, 32'h0,    1, 1, 0, 0, 32'h0};
        vt[1]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 5, 32'h1234};
        vt[2]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 0, 0, 32'h0};
        vt[3]  = '{1, 3, 32'hA,    1, 4, 32'hB,    1, 1, 0, 0, 32'h0};
        vt[4]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 3, 32'hA};
        vt[5]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 4, 32'hB};
        vt[6]  = '{0, 0, 32'h0,    1, 0, 32'hFFFF, 1, 1, 0, 0, 32'h0};
        vt[7]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 0, 0, 32'h0};
        vt[8]  = '{1, 1, 32'h11,   1, 2, 32'h22,   1, 1, 0, 0, 32'h0};
        vt[9]  = '{1, 3, 32'h33,   1, 4, 32'h44,   1, 1, 1, 1, 32'h11};
        vt[10] = '{1, 5, 32'h55,   1, 6, 32'h66,   1, 0, 1, 2, 32'h22};
        vt[11] = '{0, 0, 32'h0,    1, 6, 32'h66,   1, 1, 1, 3, 32'h33};
        vt[12] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 4, 32'h44};
        vt[13] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 5, 32'h55};
        vt[14] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 1, 6, 32'h66};
        vt[15] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 0, 0, 32'h0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        check("reset_we", 32'(bus_if.we), 32'd0);
        check("reset_wAddr", 32'(bus_if.wAddr), 32'd0);
        check("reset_wData", bus_if.wData, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].mv, vt[i].ma, vt[i].md, vt[i].ev, vt[i].ea, vt[i].ed, 0, 0);
            @(negedge clk);
            check($sformatf("vec%0d_mem_ready", i), 32'(bus_if.mem_ready), 32'(vt[i].mr));
            check($sformatf("vec%0d_ex_ready", i), 32'(bus_if.ex_ready), 32'(vt[i].er));
            check($sformatf("vec%0d_we", i), 32'(bus_if.we), 32'(vt[i].we));
            check($sformatf("vec%0d_wAddr", i), 32'(bus_if.wAddr), 32'(vt[i].wa));
            check($sformatf("vec%0d_wData", i), bus_if.wData, vt[i].wd);
            model_ready(mr, er);
            @(posedge clk);
            model_advance(mr, er);
            #1;
        end

        // Reset with three entries pending: write port drops at once, nothing drains later.
        run_cycle(1, 1, 32'h101, 1, 2, 32'h202, 0, 0);
        run_cycle(1, 3, 32'h303, 1, 4, 32'h404, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        check("pre_rst_count", mq.size(), 32'd3);
        check("pre_rst_we", 32'(bus_if.we), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(bus_if.we), 32'd0);
        check("mid_rst_wAddr", 32'(bus_if.wAddr), 32'd0);
        check("mid_rst_wData", bus_if.wData, 32'd0);
`ifdef WB_BYPASS_EN
        check("mid_rst_fwdaHit", 32'(bus_if.fwdaHit), 32'd0);
        check("mid_rst_fwdbData", bus_if.fwdbData, 32'd0);
`endif
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef WB_BYPASS_EN
        run_cycle(1, 7, 32'h1, 1, 7, 32'h2, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        check("byp_fwdaHit", 32'(bus_if.fwdaHit), 32'd1);
        check("byp_fwdaData", bus_if.fwdaData, 32'h2);
        check("byp_fwdbHit", 32'(bus_if.fwdbHit), 32'd0);
        model_ready(mr, er);
        @(posedge clk);
        model_advance(mr, er);
        #1;
        repeat (2) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [4:0] ma, ea;
            ma = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ea = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            run_cycle(($urandom_range(0, 9) < 7), ma, $urandom,
                      ($urandom_range(0, 9) < 7), ea, $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (5) run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of pending-write entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port mem_valid  input  1  load/MEM result offered.
REQ-005 SHALL have port mem_addr  input  5  destination register of MEM result.
REQ-006 SHALL have port mem_data  input  32  MEM result value.
REQ-007 SHALL have port mem_ready  output  1  MEM result accepted this cycle when high with mem_valid.
REQ-008 SHALL have ports ex_valid / ex_addr / ex_data / ex_ready with the same widths and meaning for the EX result.
REQ-009 SHALL have ports we  output  1, wAddr  output  5, wData  output  32: register-file write port.
REQ-010 SHALL have ports regaAddr, regbAddr  input  5: decode-stage read addresses.
REQ-011 SHALL have ports fwdaHit, fwdbHit  output  1 and fwdaData, fwdbData  output  32: pending-write bypass (present only with WB_BYPASS_EN).

Function
REQ-012 SHALL hold pending writes {addr, data} in a FIFO of DEPTH entries with a count register 0..DEPTH.
REQ-013 SHALL treat a valid source with addr 0 as accepted (ready high) but SHALL NOT enqueue it.
REQ-014 SHALL compute free = DEPTH - count from registered count only; a same-cycle pop does not create space.
REQ-015 SHALL order same-cycle enqueue MEM first, EX second (MEM is older in program order).
REQ-016 SHALL assert mem_ready when free >= 1; ex_ready when free >= 2, or free >= 1 and MEM does not enqueue this cycle.
REQ-017 SHALL, when mem_ready is low, also hold ex_ready low (EX never overtakes MEM).
REQ-018 SHALL drive we = (count != 0), wAddr/wData = head entry, combinationally from registered state; pop head every cycle count != 0.
REQ-019 SHALL give latency: entry enqueued at edge N appears on we/wAddr/wData in cycle after edge N when queue was empty.
REQ-020 SHALL update count by +enqueues -pop in one edge; simultaneous 2 enqueues and 1 pop yields net +1.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; full (count == DEPTH) and empty (count == 0) never alias.
REQ-022 SHALL drive wAddr = 0, wData = 0 while empty.

Reset
REQ-023 SHALL on rst clear count and pointers immediately; we = 0, wAddr = 0, wData = 0, fwd*Hit = 0, fwd*Data = 0.
REQ-024 SHALL discard all pending entries on reset mid-operation; no write issued after rst asserts.
REQ-025 SHALL not require entry storage to be reset.

Configuration
REQ-026 SHALL with WB_BYPASS_EN defined: fwdaHit high when any valid entry matches regaAddr != 0; fwdaData = youngest matching entry's data; likewise port b.
REQ-027 SHALL without WB_BYPASS_EN: fwd* ports absent and no compare logic synthesised.
REQ-028 SHALL exclude same-cycle incoming (not yet enqueued) results from bypass.

Structure
REQ-029 SHALL place wb_entry_t {addr[4:0], data[31:0]}, REG_ZERO constant and default DEPTH in package wb_pkg.
REQ-030 SHALL implement storage/pointers in sub-module wb_fifo (2 push ports, 1 pop port, count); wb_queue holds ready/order/bypass logic.

Verification
REQ-031 SHALL verify: single MEM write r5=0x1234 into empty queue -> next cycle we=1, wAddr=5, wData=0x1234, then we=0.
REQ-032 SHALL verify: MEM r3=0xA and EX r4=0xB same cycle -> writes r3 then r4 on consecutive cycles.
REQ-033 SHALL verify: DEPTH=4, count=3, both valid -> mem_ready=1, ex_ready=0; EX accepted next cycle.
REQ-034 SHALL verify: EX r0=0xFFFF valid -> ex_ready=1, count unchanged, no we pulse.
REQ-035 SHALL verify (WB_BYPASS_EN): entries r7=0x1 then r7=0x2 pending, regaAddr=7 -> fwdaHit=1, fwdaData=0x2; regbAddr=0 -> fwdbHit=0.
REQ-036 SHALL verify: rst asserted with 3 entries pending -> we=0 same cycle, no writes after release.
